// File: rtl/io_bus_arb.sv
// io_bus_arb -- two-master arbiter for a single 6-bit I/O bus.
//
// The core and a debug port each issue single I/O transfers. One transfer
// takes three cycles:
//   IDLE  arbitrate and latch the winner's command,
//   XFER  drive the address and a one-cycle read or write strobe,
//   DONE  pulse the winner's ack.
// The core has priority. After STARVE_MAX consecutive core grants made
// while the debug port was waiting, the debug port is granted once.
//
// Ports
//   cp2                core clock, rising edge
//   ireset             asynchronous reset, active low
//   core_req/adr/wr/wdata   core request; req is held until core_ack
//   core_ack, core_rdata    core completion pulse and captured read data
//   dbg_req/adr/wr/wdata    debug-port request, same meaning as core_*
//   dbg_ack, dbg_rdata      debug completion pulse and captured read data
//   io_adr, iore, iowe, dbus_out   I/O bus address, strobes and write data
//   dbusin             muxed read data coming back from the I/O decoder
module io_bus_arb #(
  parameter int unsigned STARVE_MAX = 4  // legal range 1..7
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic       core_req,
  input  logic [5:0] core_adr,
  input  logic       core_wr,
  input  logic [7:0] core_wdata,
  output logic       core_ack,
  output logic [7:0] core_rdata,
  input  logic       dbg_req,
  input  logic [5:0] dbg_adr,
  input  logic       dbg_wr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_ack,
  output logic [7:0] dbg_rdata,
  output logic [5:0] io_adr,
  output logic       iore,
  output logic       iowe,
  output logic [7:0] dbus_out,
  input  logic [7:0] dbusin
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;   // 1 = debug port owns the transfer
  logic [5:0] adr_q, adr_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [2:0] starve_q, starve_d;
  logic [7:0] core_rdata_q, core_rdata_d;
  logic [7:0] dbg_rdata_q, dbg_rdata_d;
  logic       dbg_win;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      adr_q        <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      starve_q     <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      adr_q        <= adr_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    adr_d        = adr_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    // Debug wins when it is alone or when the core has used up its quota.
    dbg_win      = dbg_req && (!core_req || (starve_q == STARVE_LIM));

    unique case (state_q)
      S_IDLE: begin
        if (core_req || dbg_req) begin
          state_d = S_XFER;
          owner_d = dbg_win;
          if (dbg_win) begin
            adr_d    = dbg_adr;
            wr_d     = dbg_wr;
            wdata_d  = dbg_wdata;
            starve_d = '0;
          end else begin
            adr_d   = core_adr;
            wr_d    = core_wr;
            wdata_d = core_wdata;
            // Count only core grants that made the debug port wait.
            if (!dbg_req) begin
              starve_d = '0;
            end else if (starve_q < STARVE_LIM) begin
              starve_d = starve_q + 3'd1;
            end
          end
        end
      end
      S_XFER: begin
        state_d = S_DONE;
        if (!wr_q) begin
          if (owner_q) begin
            dbg_rdata_d = dbusin;
          end else begin
            core_rdata_d = dbusin;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs decode directly from the registered state, so an
  // asynchronous reset removes the strobe in the same instant.
  always_comb begin
    io_adr   = '0;
    iore     = 1'b0;
    iowe     = 1'b0;
    dbus_out = '0;
    core_ack = 1'b0;
    dbg_ack  = 1'b0;
    if (state_q == S_XFER) begin
      io_adr = adr_q;
      iore   = ~wr_q;
      iowe   = wr_q;
      if (wr_q) begin
        dbus_out = wdata_q;
      end
    end
    if (state_q == S_DONE) begin
      core_ack = ~owner_q;
      dbg_ack  = owner_q;
    end
  end

  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_io_bus_arb.sv
// Testbench for io_bus_arb: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model of the arbiter.
module tb_io_bus_arb;

  localparam int unsigned SMAX = 4;

  logic       cp2 = 1'b0;
  logic       ireset = 1'b0;
  logic       core_req = 1'b0, core_wr = 1'b0;
  logic [5:0] core_adr = '0;
  logic [7:0] core_wdata = '0;
  logic       core_ack;
  logic [7:0] core_rdata;
  logic       dbg_req = 1'b0, dbg_wr = 1'b0;
  logic [5:0] dbg_adr = '0;
  logic [7:0] dbg_wdata = '0;
  logic       dbg_ack;
  logic [7:0] dbg_rdata;
  logic [5:0] io_adr;
  logic       iore, iowe;
  logic [7:0] dbus_out;
  logic [7:0] dbusin = '0;

  io_bus_arb #(.STARVE_MAX(SMAX)) dut (
    .cp2(cp2), .ireset(ireset),
    .core_req(core_req), .core_adr(core_adr), .core_wr(core_wr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_adr(dbg_adr), .dbg_wr(dbg_wr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .io_adr(io_adr), .iore(iore), .iowe(iowe), .dbus_out(dbus_out),
    .dbusin(dbusin)
  );

  always #5 cp2 = ~cp2;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: cycles_in counts how far the current transfer has
  // progressed (0 = no transfer, 1 = bus cycle, 2 = ack cycle).
  int unsigned cycles_in;
  bit          m_dbg_owns;
  logic [5:0]  m_adr;
  bit          m_wr;
  logic [7:0]  m_wd;
  int unsigned m_waits;   // core grants the debug port has sat through
  logic [7:0]  m_crd, m_drd;

  function automatic void model_reset();
    cycles_in  = 0;
    m_dbg_owns = 0;
    m_adr      = '0;
    m_wr       = 0;
    m_wd       = '0;
    m_waits    = 0;
    m_crd      = '0;
    m_drd      = '0;
  endfunction

  function automatic void model_step();
    bit d;
    if (!ireset) begin
      model_reset();
    end else if (cycles_in == 0) begin
      if (core_req || dbg_req) begin
        d = dbg_req && (!core_req || m_waits == SMAX);
        m_dbg_owns = d;
        m_adr = d ? dbg_adr : core_adr;
        m_wr  = d ? dbg_wr : core_wr;
        m_wd  = d ? dbg_wdata : core_wdata;
        if (d || !dbg_req) m_waits = 0;
        else if (m_waits < SMAX) m_waits = m_waits + 1;
        cycles_in = 1;
      end
    end else if (cycles_in == 1) begin
      if (!m_wr) begin
        if (m_dbg_owns) m_drd = dbusin;
        else m_crd = dbusin;
      end
      cycles_in = 2;
    end else begin
      cycles_in = 0;
    end
  endfunction

  function automatic bit exp_core_ack();
    return cycles_in == 2 && !m_dbg_owns;
  endfunction

  function automatic bit exp_dbg_ack();
    return cycles_in == 2 && m_dbg_owns;
  endfunction

  task automatic check_all();
    bit on_bus;
    on_bus = (cycles_in == 1);
    chk("io_adr",     io_adr,     on_bus ? m_adr : 6'd0);
    chk("iore",       iore,       on_bus && !m_wr);
    chk("iowe",       iowe,       on_bus && m_wr);
    chk("dbus_out",   dbus_out,   (on_bus && m_wr) ? m_wd : 8'd0);
    chk("core_ack",   core_ack,   exp_core_ack());
    chk("dbg_ack",    dbg_ack,    exp_dbg_ack());
    chk("core_rdata", core_rdata, m_crd);
    chk("dbg_rdata",  dbg_rdata,  m_drd);
    chk("ack_excl",   core_ack & dbg_ack, 1'b0);
  endtask

  // Acks observed on the DUT, in order: 0 = core, 1 = debug.
  bit ack_log[$];

  task automatic tick();
    model_step();
    @(posedge cp2);
    @(negedge cp2);
    check_all();
    if (core_ack) ack_log.push_back(1'b0);
    if (dbg_ack) ack_log.push_back(1'b1);
  endtask

  task automatic do_reset();
    ireset = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    ireset = 1'b1;
  endtask

  // Requesters follow the bus protocol: drop in the ack cycle, otherwise
  // raise with probability p_raise% and abandon with probability p_drop%.
  task automatic drive_reqs(input int unsigned p_raise, input int unsigned p_drop);
    if (exp_core_ack()) core_req = 1'b0;
    else if (!core_req) begin
      if ($urandom_range(99) < p_raise) begin
        core_req = 1'b1; core_adr = 6'($urandom);
        core_wr = 1'($urandom); core_wdata = 8'($urandom);
      end
    end else if ($urandom_range(99) < p_drop) core_req = 1'b0;
    if (exp_dbg_ack()) dbg_req = 1'b0;
    else if (!dbg_req) begin
      if ($urandom_range(99) < p_raise) begin
        dbg_req = 1'b1; dbg_adr = 6'($urandom);
        dbg_wr = 1'($urandom); dbg_wdata = 8'($urandom);
      end
    end else if ($urandom_range(99) < p_drop) dbg_req = 1'b0;
    dbusin = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    @(negedge cp2);
    do_reset();
    chk("rst_state", {28'd0, iore, iowe, core_ack, dbg_ack}, 32'd0);

    // Core read of 0x3F.
    core_req = 1; core_adr = 6'h3F; core_wr = 0; dbusin = 8'hA5;
    tick();
    chk("r037_iore", iore, 1'b1);
    chk("r037_adr", io_adr, 6'h3F);
    tick();
    chk("r037_ack", core_ack, 1'b1);
    chk("r037_rdata", core_rdata, 8'hA5);
    chk("r037_dbgrd", dbg_rdata, 8'h00);
    core_req = 0;
    tick();

    // Debug write of 0x5A to 0x3D.
    dbg_req = 1; dbg_adr = 6'h3D; dbg_wr = 1; dbg_wdata = 8'h5A;
    tick();
    chk("r038_iowe", iowe, 1'b1);
    chk("r038_adr", io_adr, 6'h3D);
    chk("r038_dout", dbus_out, 8'h5A);
    chk("r038_iore", iore, 1'b0);
    tick();
    chk("r038_ack", dbg_ack, 1'b1);
    chk("r038_iowe_off", iowe, 1'b0);
    dbg_req = 0;
    tick();

    // Early drop during the bus cycle still completes.
    core_req = 1; core_adr = 6'h05; core_wr = 1; core_wdata = 8'hC3;
    tick();
    core_req = 0;
    tick();
    chk("r042_ack", core_ack, 1'b1);
    tick();

    // Simultaneous first request from reset.
    do_reset();
    core_req = 1; core_adr = 6'h01; core_wr = 0;
    dbg_req = 1; dbg_adr = 6'h02; dbg_wr = 0; dbusin = 8'h3C;
    tick();
    chk("r040_starve", dut.starve_q, 3'd1);
    tick();
    chk("r040_core_first", core_ack, 1'b1);
    core_req = 0; dbusin = 8'h96;
    tick();
    tick();
    tick();
    chk("r040_dbg_next", dbg_ack, 1'b1);
    chk("r040_dbg_rd", dbg_rdata, 8'h96);
    dbg_req = 0;
    tick();

    // Reset in the middle of a core read.
    do_reset();
    core_req = 1; core_adr = 6'h11; core_wr = 0; dbusin = 8'h77;
    tick();
    chk("r041_iore_pre", iore, 1'b1);
    core_req = 0; dbg_req = 1; dbg_adr = 6'h22; dbg_wr = 0;
    ireset = 0;
    #1;
    model_reset();
    chk("r041_iore_drop", iore, 1'b0);
    check_all();
    tick();
    tick();
    chk("r041_no_rd", core_rdata, 8'h00);
    ireset = 1;
    tick();
    chk("r041_dbg_bus", io_adr, 6'h22);
    tick();
    chk("r041_dbg_ack", dbg_ack, 1'b1);
    dbg_req = 0;
    tick();

    // Both sides continuously busy: four core transfers per debug transfer.
    do_reset();
    ack_log.delete();
    for (int i = 0; i < 60; i++) begin
      drive_reqs(100, 0);
      tick();
    end
    core_req = 0; dbg_req = 0;
    tick(); tick(); tick();
    n = ack_log.size();
    chk("starve_nacks", n, 32'd20);
    for (int k = 0; k < ack_log.size(); k++)
      chk("starve_pattern", ack_log[k], (k % 5) == 4);

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_reqs(40, 5);
      if ($urandom_range(499) == 0) begin
        ireset = 0;
        #1;
        model_reset();
        check_all();
        tick();
        ireset = 1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
